// File: rtl/dmem_lsu_if.sv
// Bundle of core-side request/response signals and cache-side port signals
// for the load/store unit.
//
// Core handshake: a request transfers on a rising edge where cpu_req and
// cpu_ready are both high. The unit then drops cpu_ready until it answers
// with a single-cycle cpu_ack (cpu_err and cpu_rdata valid alongside). The
// ack cycle is itself a ready cycle, so the next request may transfer there.
interface dmem_lsu_if;
    logic        cpu_req;
    logic        cpu_ready;
    logic        cpu_we;
    logic [1:0]  cpu_size;
    logic        cpu_unsigned;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic        dmwr_req;
    logic [3:0]  dmwr_mask;
    logic [31:0] dmdata_in;
    logic [31:0] dmaddr;
    logic [31:0] dmdata_out1;

    // Environment side: the core issuing requests and the cache returning data.
    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
        output dmdata_out1,
        input  cpu_ready, cpu_rdata, cpu_ack, cpu_err,
        input  dmwr_req, dmwr_mask, dmdata_in, dmaddr
    );

    // Load/store unit side.
    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
        input  dmdata_out1,
        output cpu_ready, cpu_rdata, cpu_ack, cpu_err,
        output dmwr_req, dmwr_mask, dmdata_in, dmaddr
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-wide data cache. Sub-word stores are
// done as read-modify-write so the cache only ever sees full-word writes;
// loads get lane extraction and sign/zero extension.
module dmem_lsu #(
    parameter int MEM_WORDS_LOG2 = 6,
    parameter bit RANGE_CHECK    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_lsu_if.slave  bus,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_WR    = 3'd2;
    localparam logic [2:0] S_LDONE = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [1:0]  a_size;
    logic        a_we;
    logic        a_uns;

    logic        accept;
    logic        acc_err;
    logic        range_err;
    logic [31:0] addr_hi;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [31:0] wr_word;

    assign bus.cpu_ready = (state == S_IDLE);
    assign accept        = bus.cpu_req && bus.cpu_ready;
    assign dbg_state     = state;

    // Bits above the cache depth must be zero when range checking is on.
    assign addr_hi   = bus.cpu_addr >> (MEM_WORDS_LOG2 + 2);
    assign range_err = RANGE_CHECK && (addr_hi != 32'd0);

    // Request-time error decode: illegal size, misalignment, out of range.
    always_comb begin
        acc_err = range_err;
        case (bus.cpu_size)
            SZ_HALF: if (bus.cpu_addr[0])          acc_err = 1'b1;
            SZ_WORD: if (bus.cpu_addr[1:0] != 2'b00) acc_err = 1'b1;
            2'b11:   acc_err = 1'b1;
            default: ;
        endcase
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (acc_err)
                        state_nxt = S_ERR;
                    else if (bus.cpu_we && bus.cpu_size == SZ_WORD)
                        state_nxt = S_WR;
                    else
                        state_nxt = S_RD;
                end
            end
            S_RD:    state_nxt = a_we ? S_WR : S_LDONE;
            S_WR:    state_nxt = S_IDLE;
            S_LDONE: state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Load path: pick the addressed lane from the cache word and extend it.
    always_comb begin
        ld_byte = bus.dmdata_out1[{a_addr[1:0], 3'b000} +: 8];
        ld_half = a_addr[1] ? bus.dmdata_out1[31:16] : bus.dmdata_out1[15:0];
        case (a_size)
            SZ_BYTE: ld_val = a_uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_val = a_uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_val = bus.dmdata_out1;
        endcase
    end

    // Store path: word stores pass through, sub-word stores merge into the
    // word read back from the cache in the preceding RD cycle.
    always_comb begin
        wr_word = bus.dmdata_out1;
        case (a_size)
            SZ_BYTE: wr_word[{a_addr[1:0], 3'b000} +: 8] = a_wdata[7:0];
            SZ_HALF: wr_word[{a_addr[1], 4'b0000} +: 16] = a_wdata[15:0];
            default: wr_word = a_wdata;
        endcase
    end

    // The write strobe is cut by reset in the same cycle so an aborted
    // read-modify-write never reaches the cache.
    assign bus.dmwr_req  = (state == S_WR) && !rst;
    assign bus.dmwr_mask = bus.dmwr_req ? 4'b1111 : 4'b0000;
    assign bus.dmdata_in = (state == S_WR) ? wr_word : 32'd0;

    // State, latched request and registered core responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            a_addr        <= 32'd0;
            a_wdata       <= 32'd0;
            a_size        <= 2'b00;
            a_we          <= 1'b0;
            a_uns         <= 1'b0;
            bus.cpu_rdata <= 32'd0;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_err   <= 1'b0;
            bus.dmaddr    <= 32'd0;
        end else begin
            state       <= state_nxt;
            bus.cpu_ack <= 1'b0;
            bus.cpu_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_addr  <= bus.cpu_addr;
                        a_wdata <= bus.cpu_wdata;
                        a_size  <= bus.cpu_size;
                        a_we    <= bus.cpu_we;
                        a_uns   <= bus.cpu_unsigned;
                        // Erroneous requests leave the cache address alone.
                        if (!acc_err)
                            bus.dmaddr <= {2'b00, bus.cpu_addr[31:2]};
                    end
                end
                S_WR: bus.cpu_ack <= 1'b1;
                S_LDONE: begin
                    bus.cpu_rdata <= ld_val;
                    bus.cpu_ack   <= 1'b1;
                end
                S_ERR: begin
                    bus.cpu_rdata <= 32'd0;
                    bus.cpu_ack   <= 1'b1;
                    bus.cpu_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a vector table of requests with hand-computed
// responses, plus sequences for reset, back-to-back and reset-abort cases.
module tb_dmem_lsu;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    dmem_lsu_if bus ();

    dmem_lsu #(
        .MEM_WORDS_LOG2(6),
        .RANGE_CHECK   (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- cache model: masked write, registered read ----------------
    logic [31:0] mem [64] = '{default: 32'd0};
    logic [31:0] mask_exp;

    assign mask_exp = {{8{bus.dmwr_mask[3]}}, {8{bus.dmwr_mask[2]}},
                       {8{bus.dmwr_mask[1]}}, {8{bus.dmwr_mask[0]}}};

    // Cache behaviour: write data AND mask, otherwise read dmaddr with one cycle latency.
    always @(posedge clk) begin
        if (bus.dmwr_req)
            mem[bus.dmaddr[5:0]] <= bus.dmdata_in & mask_exp;
        else
            bus.dmdata_out1 <= mem[bus.dmaddr[5:0]];
    end

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Entered and left at #1 after a rising edge. Cycle k is observed at #1
    // after edge E(k-1), where E0 is the accept edge.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int ack_cyc, output logic err, output logic [31:0] rdata,
                          output int wr_cyc, output int wr_cnt,
                          output logic [31:0] wr_din, output logic [31:0] wr_addr,
                          output logic [3:0] wr_mask);
        ack_cyc = 0; err = 1'b0; rdata = 32'd0;
        wr_cyc = 0; wr_cnt = 0; wr_din = 32'd0; wr_addr = 32'd0; wr_mask = 4'd0;
        for (int i = 0; i < 8 && !bus.cpu_ready; i++) begin
            @(posedge clk); #1;
        end
        bus.cpu_req      = 1'b1;
        bus.cpu_we       = we;
        bus.cpu_size     = size;
        bus.cpu_unsigned = uns;
        bus.cpu_addr     = addr;
        bus.cpu_wdata    = wdata;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.dmwr_req) begin
                if (wr_cnt == 0) begin
                    wr_cyc  = k;
                    wr_din  = bus.dmdata_in;
                    wr_addr = bus.dmaddr;
                    wr_mask = bus.dmwr_mask;
                end
                wr_cnt++;
            end
            if (bus.cpu_ack) begin
                ack_cyc = k;
                err     = bus.cpu_err;
                rdata   = bus.cpu_rdata;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_ack;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_wr;
        logic [31:0] exp_din;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int          ack_cyc, wr_cyc, wr_cnt;
        logic        err;
        logic [31:0] rdata, wr_din, wr_addr;
        logic [3:0]  wr_mask;
        logic        saw_ack;
        int          b2b_cyc;

        //           we    size   uns   addr        wdata          ack err  rdata          wr din
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 2, 1'b0, 32'h0,         1, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        3, 1'b0, 32'hDEADBEEF,  0, 32'h0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h12,  32'h55,       3, 1'b0, 32'h0,         2, 32'hDE55BEEF});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h12,  32'h0,        3, 1'b0, 32'h00000055,  0, 32'h0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        3, 1'b0, 32'hFFFFDE55,  0, 32'h0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        3, 1'b0, 32'h000000DE,  0, 32'h0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h11,  32'h1234,     2, 1'b1, 32'h0,         0, 32'h0});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        2, 1'b1, 32'h0,         0, 32'h0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        2, 1'b1, 32'h0,         0, 32'h0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h12,  32'h0,        2, 1'b1, 32'h0,         0, 32'h0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h16,  32'h1234ABCD, 3, 1'b0, 32'h0,         2, 32'hABCD0000});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h16,  32'h0,        3, 1'b0, 32'h0000ABCD,  0, 32'h0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h16,  32'h0,        3, 1'b0, 32'hFFFFABCD,  0, 32'h0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h17,  32'h0,        3, 1'b0, 32'hFFFFFFAB,  0, 32'h0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h10,  32'hFFFFFF80, 3, 1'b0, 32'h0,         2, 32'hDE55BE80});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h10,  32'h0,        3, 1'b0, 32'hFFFFFF80,  0, 32'h0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        3, 1'b0, 32'hDE55BE80,  0, 32'h0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'hFC,  32'h01020304, 2, 1'b0, 32'h0,         1, 32'h01020304});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'hFD,  32'h0,        3, 1'b0, 32'h00000003,  0, 32'h0});

        // ---------------- reset ----------------
        rst              = 1'b1;
        bus.cpu_req      = 1'b0;
        bus.cpu_we       = 1'b0;
        bus.cpu_size     = 2'b00;
        bus.cpu_unsigned = 1'b0;
        bus.cpu_addr     = 32'd0;
        bus.cpu_wdata    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dmwr_req_held", {31'd0, bus.dmwr_req}, 32'd0);
        rst = 1'b0;
        check("rst_ready",  {31'd0, bus.cpu_ready}, 32'd1);
        check("rst_ack",    {31'd0, bus.cpu_ack},   32'd0);
        check("rst_err",    {31'd0, bus.cpu_err},   32'd0);
        check("rst_dmwr",   {31'd0, bus.dmwr_req},  32'd0);
        check("rst_mask",   {28'd0, bus.dmwr_mask}, 32'd0);
        check("rst_dmaddr", bus.dmaddr,             32'd0);
        check("rst_din",    bus.dmdata_in,          32'd0);
        check("rst_rdata",  bus.cpu_rdata,          32'd0);
        check("rst_state",  {29'd0, dbg_state},     {29'd0, S_IDLE});

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   ack_cyc, err, rdata, wr_cyc, wr_cnt, wr_din, wr_addr, wr_mask);
            check($sformatf("v%0d_ack_cycle", i), ack_cyc, vecs[i].exp_ack);
            check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_wr_count", i), wr_cnt, (vecs[i].exp_wr != 0) ? 1 : 0);
            if (!vecs[i].we || vecs[i].exp_err)
                check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            if (vecs[i].exp_wr != 0) begin
                check($sformatf("v%0d_wr_cycle", i), wr_cyc, vecs[i].exp_wr);
                check($sformatf("v%0d_wr_data", i), wr_din, vecs[i].exp_din);
                check($sformatf("v%0d_wr_addr", i), wr_addr, {2'b00, vecs[i].addr[31:2]});
                check($sformatf("v%0d_wr_mask", i), {28'd0, wr_mask}, 32'hF);
            end
        end

        // ---------------- back-to-back: request held through the ack cycle ----------------
        bus.cpu_req      = 1'b1;
        bus.cpu_we       = 1'b1;
        bus.cpu_size     = 2'b10;
        bus.cpu_unsigned = 1'b0;
        bus.cpu_addr     = 32'h20;
        bus.cpu_wdata    = 32'hCAFEF00D;
        @(posedge clk); #1;                       // cycle 1: WR of the store
        bus.cpu_we    = 1'b0;
        bus.cpu_wdata = 32'd0;
        check("b2b_busy_ready", {31'd0, bus.cpu_ready}, 32'd0);
        @(posedge clk); #1;                       // cycle 2: store ack, load accepted at next edge
        check("b2b_store_ack",   {31'd0, bus.cpu_ack},   32'd1);
        check("b2b_ready_in_ack", {31'd0, bus.cpu_ready}, 32'd1);
        @(posedge clk); #1;                       // cycle 3: load already in RD
        bus.cpu_req = 1'b0;
        check("b2b_load_accepted", {29'd0, dbg_state}, {29'd0, S_RD});
        b2b_cyc = 0;
        rdata   = 32'd0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (bus.cpu_ack) begin
                b2b_cyc = k;
                rdata   = bus.cpu_rdata;
                break;
            end
        end
        check("b2b_load_ack_delay", b2b_cyc, 2);
        check("b2b_load_rdata", rdata, 32'hCAFEF00D);

        // ---------------- reset during the WR cycle of a byte store ----------------
        bus.cpu_req      = 1'b1;
        bus.cpu_we       = 1'b1;
        bus.cpu_size     = 2'b00;
        bus.cpu_unsigned = 1'b0;
        bus.cpu_addr     = 32'h10;
        bus.cpu_wdata    = 32'h11;
        @(posedge clk); #1;                       // cycle 1: RD
        bus.cpu_req = 1'b0;
        check("abort_rd_state", {29'd0, dbg_state}, {29'd0, S_RD});
        @(posedge clk); #1;                       // cycle 2: WR
        check("abort_wr_before_rst", {31'd0, bus.dmwr_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_wr_gated", {31'd0, bus.dmwr_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_state_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
        saw_ack = bus.cpu_ack;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.cpu_ack) saw_ack = 1'b1;
        end
        check("abort_no_ack", {31'd0, saw_ack}, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
               ack_cyc, err, rdata, wr_cyc, wr_cnt, wr_din, wr_addr, wr_mask);
        check("abort_readback_ack", ack_cyc, 3);
        check("abort_readback_word", rdata, 32'hDE55BE80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
